// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register map constants shared by the timer top and channels
package timer_pkg;

    localparam int          CH_STRIDE = 16;
    localparam logic [11:0] OFF_CYCLE = 12'h100;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_IE     = 2;
    localparam int CTRL_STATUS = 3;

    // Register select is offset[3:2] inside a channel's 16-byte window
    typedef enum logic [1:0] {
        REG_CTRL     = 2'd0,
        REG_LOAD     = 2'd1,
        REG_COUNT    = 2'd2,
        REG_PRESCALE = 2'd3
    } reg_sel_e;

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one down-counting timer channel with prescaler and expiry interrupt
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  reg_sel_e    reg_sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic                  en;
    logic                  auto_rl;
    logic                  ie;
    logic                  status;
    logic [WIDTH-1:0]      load;
    logic [WIDTH-1:0]      count;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pcnt;

    logic wr_ctrl;
    logic wr_load;
    logic wr_count;
    logic wr_prescale;
    logic tick;
    logic tick_live;
    logic expire;

    assign wr_ctrl     = wr_en && (reg_sel == REG_CTRL);
    assign wr_load     = wr_en && (reg_sel == REG_LOAD);
    assign wr_count    = wr_en && (reg_sel == REG_COUNT);
    assign wr_prescale = wr_en && (reg_sel == REG_PRESCALE);

    // A CTRL write that clears EN swallows a tick landing on the same edge
    assign tick      = en && (pcnt == prescale);
    assign tick_live = tick && !(wr_ctrl && !wdata[CTRL_EN]);
    assign expire    = tick_live && (count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en       <= 1'b0;
            auto_rl  <= 1'b0;
            ie       <= 1'b0;
            status   <= 1'b0;
            load     <= '0;
            count    <= '0;
            prescale <= '0;
            pcnt     <= '0;
        end else begin
            if (wr_ctrl && wdata[CTRL_EN] && !en) begin
                pcnt <= '0;
            end else if (en) begin
                pcnt <= tick ? '0 : pcnt + PRESCALE_W'(1);
            end

            if (wr_count) begin
                count <= wdata[WIDTH-1:0];
            end else if (expire) begin
                if (auto_rl) begin
                    count <= load;
                end
            end else if (tick_live) begin
                count <= count - WIDTH'(1);
            end

            // Expiry set beats a same-cycle write-1-to-clear
            if (expire) begin
                status <= 1'b1;
            end else if (wr_ctrl && wdata[CTRL_STATUS]) begin
                status <= 1'b0;
            end

            if (wr_ctrl) begin
                en      <= wdata[CTRL_EN];
                auto_rl <= wdata[CTRL_AUTO];
                ie      <= wdata[CTRL_IE];
            end else if (expire && !auto_rl) begin
                en <= 1'b0;
            end

            if (wr_load) begin
                load <= wdata[WIDTH-1:0];
            end
            if (wr_prescale) begin
                prescale <= wdata[PRESCALE_W-1:0];
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_CTRL:     rdata = {28'd0, status, ie, auto_rl, en};
            REG_LOAD:     rdata = 32'(load);
            REG_COUNT:    rdata = 32'(count);
            REG_PRESCALE: rdata = 32'(prescale);
            default:      rdata = '0;
        endcase
    end

    assign irq = status && ie;

endmodule

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - memory-mapped multi-channel timer with free-running cycle counter
module mmio_timer
    import timer_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter int          NUM_CH     = 2,
    parameter int          PRESCALE_W = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h40000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        irq
);

    logic             hit;
    logic [11:0]      offset;
    logic             ch_hit;
    logic             cyc_hit;
    logic [2:0]       ch_idx;
    reg_sel_e         reg_sel;
    logic [WIDTH-1:0] cycle;

    logic [31:0]       ch_rdata [NUM_CH];
    logic [NUM_CH-1:0] ch_irq;

    assign hit     = (Address[31:12] == BASE_ADDR[31:12]);
    assign offset  = Address[11:0];
    assign ch_hit  = hit && (offset < 12'(CH_STRIDE * NUM_CH)) && (offset[1:0] == 2'b00);
    assign cyc_hit = hit && (offset == OFF_CYCLE);
    assign ch_idx  = offset[6:4];
    assign reg_sel = reg_sel_e'(offset[3:2]);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_channel #(
            .WIDTH      (WIDTH),
            .PRESCALE_W (PRESCALE_W)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (MemWrite && ch_hit && (ch_idx == 3'(i))),
            .reg_sel (reg_sel),
            .wdata   (Write_data),
            .rdata   (ch_rdata[i]),
            .irq     (ch_irq[i])
        );
    end

    // Read-only; bus writes to its offset fall through the decode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle <= '0;
        end else begin
            cycle <= cycle + WIDTH'(1);
        end
    end

    always_comb begin
        Read_data = '0;
        if (MemRead) begin
            if (cyc_hit) begin
                Read_data = 32'(cycle);
            end else if (ch_hit) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_idx == 3'(i)) begin
                        Read_data = ch_rdata[i];
                    end
                end
            end
        end
    end

    assign irq = |ch_irq;

endmodule

// File: tb/tb_mmio_timer.sv
// tb/tb_mmio_timer.sv - self-checking bench for mmio_timer with a behavioural register model
module tb_mmio_timer;

    localparam int          NUM_CH = 4;
    localparam logic [31:0] BASE   = 32'h40000000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Address = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Write_data = '0;
    logic [31:0] Read_data;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    int m_en [NUM_CH];
    int m_auto [NUM_CH];
    int m_ie [NUM_CH];
    int m_status [NUM_CH];
    int m_load [NUM_CH];
    int m_count [NUM_CH];
    int m_pres [NUM_CH];
    int m_pcnt [NUM_CH];
    int m_cycle;

    always #5 clk = ~clk;

    mmio_timer #(
        .WIDTH      (8),
        .NUM_CH     (NUM_CH),
        .PRESCALE_W (8),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .irq        (irq)
    );

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_en[c] = 0; m_auto[c] = 0; m_ie[c] = 0; m_status[c] = 0;
            m_load[c] = 0; m_count[c] = 0; m_pres[c] = 0; m_pcnt[c] = 0;
        end
        m_cycle = 0;
    endfunction

    // One clock of the register-level behaviour, from the bus operation seen at that edge
    function automatic void model_step(input bit we, input logic [31:0] a, input logic [31:0] d);
        int off = int'(a[11:0]);
        bit chw = we && (a[31:12] == BASE[31:12]) && (off < 16 * NUM_CH) && (off % 4 == 0);
        for (int c = 0; c < NUM_CH; c++) begin
            bit sel    = chw && (off / 16 == c);
            int r      = (off % 16) / 4;
            bit wctrl  = sel && (r == 0);
            bit tick   = (m_en[c] != 0) && (m_pcnt[c] == m_pres[c]);
            bit live   = tick && !(wctrl && !d[0]);
            bit expire = live && (m_count[c] == 0);
            int nc     = m_count[c];
            int np     = m_pcnt[c];
            if (m_en[c] != 0) np = tick ? 0 : (m_pcnt[c] + 1) % 256;
            if (wctrl && d[0] && m_en[c] == 0) np = 0;
            if (sel && r == 2) nc = int'(d[7:0]);
            else if (expire) nc = (m_auto[c] != 0) ? m_load[c] : 0;
            else if (live) nc = m_count[c] - 1;
            if (expire) m_status[c] = 1;
            else if (wctrl && d[3]) m_status[c] = 0;
            if (wctrl) begin
                m_en[c] = int'(d[0]); m_auto[c] = int'(d[1]); m_ie[c] = int'(d[2]);
            end else if (expire && m_auto[c] == 0) begin
                m_en[c] = 0;
            end
            if (sel && r == 1) m_load[c] = int'(d[7:0]);
            if (sel && r == 3) m_pres[c] = int'(d[7:0]);
            m_count[c] = nc;
            m_pcnt[c]  = np;
        end
        m_cycle = (m_cycle + 1) % 256;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int off = int'(a[11:0]);
        int c;
        if (a[31:12] != BASE[31:12]) return 32'd0;
        if (off == 'h100) return 32'(m_cycle);
        if (off >= 16 * NUM_CH || off % 4 != 0) return 32'd0;
        c = off / 16;
        case ((off % 16) / 4)
            0: return 32'(m_status[c] * 8 + m_ie[c] * 4 + m_auto[c] * 2 + m_en[c]);
            1: return 32'(m_load[c]);
            2: return 32'(m_count[c]);
            default: return 32'(m_pres[c]);
        endcase
    endfunction

    function automatic logic model_irq();
        logic r = 1'b0;
        for (int c = 0; c < NUM_CH; c++) r |= (m_status[c] != 0) && (m_ie[c] != 0);
        return r;
    endfunction

    task automatic step_clk(input bit we, input logic [31:0] a, input logic [31:0] d);
        Address = a; Write_data = d; MemWrite = we; MemRead = 1'b0;
        @(posedge clk);
        if (reset) model_step(we, a, d);
        else model_reset();
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step_clk(1'b1, a, d);
    endtask

    task automatic idle();
        step_clk(1'b0, 32'd0, 32'd0);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        Address = a; MemRead = 1'b1;
        #1;
        v = Read_data;
        MemRead = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] addrs [9];
        addrs = '{BASE + 'h0, BASE + 'h8, BASE + 'hC, BASE + 'h10, BASE + 'h18,
                  BASE + 'h30, BASE + 'h34, BASE + 'h38, BASE + 'h100};
        wr(BASE + 'h8, 32'd50);
        wr(BASE + 'h0, 32'h5);
        repeat (3) idle();
        #2 reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", irq); end
        foreach (addrs[i]) begin
            @(negedge clk);
            rd(addrs[i], v);
            n_checks++;
            if (v !== 32'd0) begin n_fail++; $display("FAIL reset_reg addr %h got %h exp 0", addrs[i], v); end
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) idle();
            rd(BASE + 'h100, v);
            n_checks++;
            if (v !== 32'(i)) begin n_fail++; $display("FAIL reset_cycle i=%0d got %h exp %h", i, v, i); end
        end
        rd(BASE + 'h8, v);
        n_checks++;
        if (v !== 32'd0 || irq !== 1'b0) begin n_fail++; $display("FAIL reset_after count %h irq %b exp 0 0", v, irq); end
    endtask

    task automatic test_one_shot();
        logic [31:0] v;
        wr(BASE + 'h4, 32'h55);
        wr(BASE + 'h8, 32'd3);
        wr(BASE + 'hC, 32'd1);
        wr(BASE + 'h0, 32'h5);
        for (int k = 1; k <= 8; k++) begin
            idle();
            rd(BASE + 'h0, v);
            n_checks++;
            if (v !== ((k < 8) ? 32'h5 : 32'hC) || irq !== (k == 8)) begin
                n_fail++; $display("FAIL oneshot k=%0d ctrl %h irq %b exp %h %b", k, v, irq, (k < 8) ? 5 : 12, k == 8);
            end
        end
        repeat (4) idle();
        rd(BASE + 'h8, v);
        n_checks++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL oneshot_hold count %h exp 0", v); end
        wr(BASE + 'h0, 32'h8);
        rd(BASE + 'h0, v);
        n_checks++;
        if (v !== 32'd0 || irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_clear ctrl %h irq %b exp 0 0", v, irq); end
    endtask

    task automatic test_auto_reload();
        logic [31:0] v;
        logic [31:0] c;
        int exp_seq [6] = '{2, 1, 0, 2, 1, 0};
        wr(BASE + 'h14, 32'd2);
        wr(BASE + 'h18, 32'd2);
        wr(BASE + 'h1C, 32'd0);
        wr(BASE + 'h10, 32'h3);
        for (int j = 0; j < 6; j++) begin
            if (j != 0) idle();
            rd(BASE + 'h18, v);
            rd(BASE + 'h10, c);
            n_checks++;
            if (v !== 32'(exp_seq[j]) || c !== ((j < 3) ? 32'h3 : 32'hB)) begin
                n_fail++; $display("FAIL auto j=%0d count %h ctrl %h exp %h %h", j, v, c, exp_seq[j], (j < 3) ? 3 : 11);
            end
        end
        wr(BASE + 'h10, 32'h8);
    endtask

    task automatic test_w1c_race();
        logic [31:0] v;
        wr(BASE + 'h8, 32'd1);
        wr(BASE + 'hC, 32'd0);
        wr(BASE + 'h0, 32'h5);
        idle();
        wr(BASE + 'h0, 32'hD);
        rd(BASE + 'h0, v);
        n_checks++;
        if (v !== 32'hD || irq !== 1'b1) begin n_fail++; $display("FAIL w1c_race ctrl %h irq %b exp d 1", v, irq); end
        idle();
        rd(BASE + 'h0, v);
        n_checks++;
        if (v !== 32'hC || irq !== 1'b1) begin n_fail++; $display("FAIL w1c_reexpire ctrl %h irq %b exp c 1", v, irq); end
        wr(BASE + 'h0, 32'h8);
        rd(BASE + 'h0, v);
        n_checks++;
        if (v !== 32'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL w1c_clear ctrl %h irq %b exp 0 0", v, irq); end
    endtask

    task automatic test_write_priority();
        logic [31:0] v;
        wr(BASE + 'h28, 32'd5);
        wr(BASE + 'h2C, 32'd0);
        wr(BASE + 'h20, 32'h1);
        wr(BASE + 'h28, 32'd9);
        rd(BASE + 'h28, v);
        n_checks++;
        if (v !== 32'd9) begin n_fail++; $display("FAIL count_write_wins got %h exp 9", v); end
        wr(BASE + 'h20, 32'h0);
        rd(BASE + 'h28, v);
        n_checks++;
        if (v !== 32'd9) begin n_fail++; $display("FAIL en_off_drops_tick got %h exp 9", v); end
    endtask

    task automatic test_bus_edges();
        logic [31:0] v;
        logic [31:0] c0;
        logic [31:0] bad [3];
        bad = '{BASE + 'h104, BASE + 'h40, 32'h50000008};
        foreach (bad[i]) begin
            rd(bad[i], v);
            n_checks++;
            if (v !== 32'd0) begin n_fail++; $display("FAIL unmapped addr %h got %h exp 0", bad[i], v); end
            idle();
        end
        Address = BASE + 'h100; MemRead = 1'b0;
        #1;
        n_checks++;
        if (Read_data !== 32'd0) begin n_fail++; $display("FAIL memread_low got %h exp 0", Read_data); end
        @(negedge clk);
        model_step(1'b0, 32'd0, 32'd0);
        rd(BASE + 'h100, c0);
        wr(BASE + 'h100, 32'h77);
        rd(BASE + 'h100, v);
        n_checks++;
        if (v !== 32'(m_cycle) || v !== ((c0 + 32'd1) & 32'hFF)) begin
            n_fail++; $display("FAIL cycle_write_ignored got %h exp %h", v, m_cycle);
        end
    endtask

    task automatic test_params();
        logic [31:0] v;
        wr(BASE + 'h38, 32'h1FF);
        rd(BASE + 'h38, v);
        n_checks++;
        if (v !== 32'hFF) begin n_fail++; $display("FAIL ch3_trunc got %h exp ff", v); end
        repeat (255 - m_cycle) idle();
        rd(BASE + 'h100, v);
        n_checks++;
        if (v !== 32'hFF) begin n_fail++; $display("FAIL cycle_max got %h exp ff", v); end
        idle();
        rd(BASE + 'h100, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL cycle_wrap got %h exp 0", v); end
    endtask

    task automatic test_random();
        logic [31:0] v;
        logic [31:0] a;
        logic [31:0] d;
        int c;
        int r;
        for (int it = 0; it < 400; it++) begin
            c = $urandom_range(0, NUM_CH - 1);
            r = $urandom_range(0, 3);
            case (r)
                0: d = 32'($urandom_range(0, 15));
                3: d = 32'($urandom_range(0, 2));
                default: d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 6));
            endcase
            a = BASE + 32'(c * 16 + r * 4);
            if ($urandom_range(0, 9) == 0) a = BASE + 'h100;
            if ($urandom_range(0, 9) == 0) a = 32'h7000_0000 | a;
            step_clk(1'($urandom_range(0, 1)), a, d);
            a = ($urandom_range(0, 4) == 0) ? BASE + 'h100 : BASE + 32'($urandom_range(0, NUM_CH - 1) * 16 + $urandom_range(0, 3) * 4);
            rd(a, v);
            n_checks++;
            if (v !== model_read(a) || irq !== model_irq()) begin
                n_fail++; $display("FAIL random it=%0d addr %h got %h irq %b exp %h %b", it, a, v, irq, model_read(a), model_irq());
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_w1c_race();
        test_write_priority();
        test_bus_edges();
        test_params();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped, parametrised multi-channel timer peripheral on the processor data bus, next to data memory. Provides NUM_CH independent down-counting timers, each with a prescaler, one-shot or auto-reload mode and an interrupt. It also provides one read-only free-running cycle counter at a fixed offset, which software uses for cycle measurement. All registers are read combinationally and written synchronously through the Address/MemRead/MemWrite bus.

## Interface
- WIDTH, 32: counter, load and cycle-counter width (1..32); reads zero-extended to 32 bits.
- NUM_CH, 2: number of timer channels (1..8).
- PRESCALE_W, 8: prescaler register width.
- BASE_ADDR, 32'h40000000: block base address, 4 KiB aligned.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- Address  in  32  byte address from the processor data path.
- MemRead  in  1  read strobe.
- MemWrite  in  1  write strobe.
- Write_data  in  32  write data.
- Read_data  out  32  read data; 0 when MemRead=0 or the address is unmapped.
- irq  out  1  OR of (STATUS & IE) over all channels.

## Operation
- Decode: hit when Address[31:12]==BASE_ADDR[31:12]. Channel n occupies offsets 0x10*n..0x10*n+0xC. Cycle counter is at offset 0x100. All other offsets read 0 and ignore writes.
- Per-channel registers:
  - +0x0 CTRL: bit0 EN, bit1 AUTO, bit2 IE, bit3 STATUS (read; writing 1 clears it, writing 0 has no effect). Other bits read 0.
  - +0x4 LOAD: reload value.
  - +0x8 COUNT: current count; a write loads it directly.
  - +0xC PRESCALE: tick divider P.
- Prescaler: while EN=1, pcnt increments every cycle. When pcnt==P, a tick is issued and pcnt returns to 0, giving one tick every P+1 cycles. A CTRL write that takes EN from 0 to 1 clears pcnt. While EN=0, pcnt holds.
- On a tick with COUNT!=0: COUNT <= COUNT-1.
- On a tick with COUNT==0 (expiry): STATUS <= 1. If AUTO=1, COUNT <= LOAD. If AUTO=0, EN <= 0 and COUNT stays 0.
- Cycle counter: increments by 1 every cycle and wraps from 2^WIDTH-1 to 0. It is read-only; writes are ignored.
- Write data is truncated to WIDTH or PRESCALE_W bits as appropriate.
- Simultaneous events:
  - A bus write to COUNT in the same cycle as a tick: the write wins.
  - A STATUS clear in the same cycle as an expiry: STATUS ends up 1 (the set wins).
  - A CTRL write of EN=0 in the same cycle as a tick: the tick is discarded.
  - A CTRL write of EN=1 in the same cycle as a one-shot expiry: EN ends up 1 (the write wins).

## Timing
- Reset (reset=0, asynchronous) clears all registers, pcnt, the cycle counter and STATUS. irq is 0 during and after reset; Read_data is 0 unless MemRead=1.
- Reset mid-count aborts the count immediately. Counting does not resume until software sets EN again.
- Read latency 0: Read_data is combinational from Address and MemRead and reflects register values from before the current edge.
- A write is visible on reads in the cycle after the edge.
- irq is registered-state derived only (STATUS & IE), so it rises the cycle after the expiry edge.
- Expiry timing: with COUNT=N, P and EN set at edge 0, STATUS rises (N+1)*(P+1) cycles later.

## Structure
- Package timer_pkg: register offsets (CTRL/LOAD/COUNT/PRESCALE/CYCLE), CTRL bit positions, channel stride 0x10.
- Sub-module timer_channel holds one channel's registers, prescaler and expiry logic. It is instantiated NUM_CH times in a generate loop.
- The top level contains the address decode, the read mux, the cycle counter and the irq OR.

## Test plan
- Reset: hold reset=0 mid-operation, then release. Every register reads 0, irq=0, and the cycle counter reads 0 then 1, 2, … on successive cycles.
- One-shot: ch0 LOAD ignored, COUNT=3, P=1, CTRL=0x5 (EN, IE). STATUS and irq rise 8 cycles after the CTRL write. EN then reads 0 and COUNT holds 0.
- Auto-reload: ch1 LOAD=2, COUNT=2, P=0, CTRL=0x3. Expiry occurs every 3 cycles and the COUNT sequence is 2,1,0,2,1,0.
- W1C race: write CTRL with bit3=1 in the exact cycle of a ch0 expiry. STATUS stays 1. A later write of 0x8 clears it and irq drops the next cycle.
- Bus edges:
  - Read offset 0x104 or an address outside BASE_ADDR → 0.
  - MemRead=0 → Read_data=0.
  - A write to 0x100 leaves the cycle counter unchanged.
- Parameters: WIDTH=8, NUM_CH=4. Writing 0x1FF to COUNT reads back 0xFF. The cycle counter wraps 0xFF→0x00. Ch3 is at offset 0x30.
